// File: rtl/mux_stim_sequencer.sv
// Buffered vector replay source for the MUX2 netlist.
// Drives {S,B,A}, holds each vector HOLD+1 cycles and checks Y.
module mux_stim_sequencer #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic [2:0]        LOAD_VEC,
  input  logic              LOAD_EXP,
  input  logic              START,
  input  logic [HOLD_W-1:0] HOLD,
  output logic              A,
  output logic              B,
  output logic              S,
  input  logic              Y,
  output logic              BUSY,
  output logic              DONE,
  output logic              MISMATCH,
  output logic [7:0]        ERR_CNT
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]        state;
  logic [PW:0]       count;
  logic [PW-1:0]     rd_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_reg;
  logic [2:0]        sba;
  logic              mm_q;
  logic [7:0]        err_q;
  logic [3:0]        mem [DEPTH];

  logic              load_hs;
  logic [PW:0]       count_nxt;
  logic [PW:0]       last_idx;
  logic [PW-1:0]     nxt_ptr;
  logic [2:0]        first_vec;
  logic [3:0]        cur;
  logic              last;

  assign LOAD_READY = (state == ST_IDLE) && (count < DEPTH_C);
  assign load_hs    = LOAD_VALID && LOAD_READY;
  assign count_nxt  = count + {{PW{1'b0}}, load_hs};
  assign last_idx   = count - (PW+1)'(1);
  assign nxt_ptr    = rd_ptr + PW'(1);
  assign cur        = mem[rd_ptr];
  assign last       = ({1'b0, rd_ptr} == last_idx);

  // Entry 0 may be written on the same edge that starts the run.
  assign first_vec = (count == '0) ? LOAD_VEC : mem[0][3:1];

  always_ff @(posedge CLK) begin
    if (load_hs) begin
      mem[count[PW-1:0]] <= {LOAD_VEC, LOAD_EXP};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      hold_cnt <= '0;
      hold_reg <= '0;
      sba      <= '0;
      mm_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      mm_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          count <= count_nxt;
          if (START) begin
            err_q    <= '0;
            hold_reg <= HOLD;
            if (count_nxt != '0) begin
              state    <= ST_DRIVE;
              rd_ptr   <= '0;
              sba      <= first_vec;
              hold_cnt <= HOLD;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_DRIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            if (Y != cur[0]) begin
              mm_q <= 1'b1;
              if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
              end
            end
            if (last) begin
              state <= ST_FINISH;
            end else begin
              rd_ptr   <= nxt_ptr;
              sba      <= mem[nxt_ptr][3:1];
              hold_cnt <= hold_reg;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          count <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {S, B, A} = sba;
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = (state == ST_FINISH);
  assign MISMATCH  = mm_q;
  assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Scoreboard bench for mux_stim_sequencer with a MUX2 model closing the loop.
// A second DEPTH=256 instance exercises ERR_CNT saturation.
module tb_mux_stim_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD_VALID = 1'b0;
  logic [2:0] LOAD_VEC = 3'b000;
  logic       LOAD_EXP = 1'b0;
  logic       START = 1'b0;
  logic [3:0] HOLD = 4'd0;
  logic       LOAD_READY, A, B, S, Y, BUSY, DONE, MISMATCH;
  logic [7:0] ERR_CNT;

  logic       b_valid = 1'b0;
  logic       b_start = 1'b0;
  logic       b_ready, b_a, b_b, b_s, b_y, b_busy, b_done, b_mm;
  logic [7:0] b_err;

  always #5 CLK = ~CLK;

  assign Y   = S ? B : A;
  assign b_y = b_s ? b_b : b_a;

  mux_stim_sequencer u_dut (
    .CLK(CLK), .RST(RST),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_VEC(LOAD_VEC), .LOAD_EXP(LOAD_EXP),
    .START(START), .HOLD(HOLD),
    .A(A), .B(B), .S(S), .Y(Y),
    .BUSY(BUSY), .DONE(DONE),
    .MISMATCH(MISMATCH), .ERR_CNT(ERR_CNT)
  );

  mux_stim_sequencer #(.DEPTH(256)) u_big (
    .CLK(CLK), .RST(RST),
    .LOAD_VALID(b_valid), .LOAD_READY(b_ready),
    .LOAD_VEC(3'b000), .LOAD_EXP(1'b1),
    .START(b_start), .HOLD(4'd0),
    .A(b_a), .B(b_b), .S(b_s), .Y(b_y),
    .BUSY(b_busy), .DONE(b_done),
    .MISMATCH(b_mm), .ERR_CNT(b_err)
  );

  typedef struct {
    int cyc;
    int err;
  } done_t;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         mm_q[$];
  done_t      done_q[$];
  logic [3:0] buf_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  name, act, exp, cyc);
  endtask

  always @(negedge CLK) begin
    done_t d;
    if (MISMATCH) begin
      if (mm_q.size() == 0) chk("unexpected_mismatch", 1, 0);
      else chk("mismatch_cyc", cyc, mm_q.pop_front());
    end
    if (DONE) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d = done_q.pop_front();
        chk("done_cyc", cyc, d.cyc);
        chk("err_cnt_at_done", int'(ERR_CNT), d.err);
        chk("busy_at_done", int'(BUSY), 1);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [2:0] v, input logic e);
    bit ok = 1'b0;
    LOAD_VALID = 1'b1;
    LOAD_VEC   = v;
    LOAD_EXP   = e;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      ok = LOAD_READY;
      tick();
    end
    LOAD_VALID = 1'b0;
    if (ok) buf_q.push_back({v, e});
    else chk("load_timeout", 0, 1);
  endtask

  // Issues START (optionally with a same-cycle load) and queues expectations.
  task automatic run(input int h, input bit wl,
                     input logic [2:0] v, input logic e);
    int         err = 0;
    int         n;
    logic [2:0] x;
    done_t      d;
    HOLD  = h[3:0];
    START = 1'b1;
    if (wl) begin
      LOAD_VALID = 1'b1;
      LOAD_VEC   = v;
      LOAD_EXP   = e;
    end
    @(negedge CLK);
    if (wl) begin
      chk("ready_with_start", int'(LOAD_READY), 1);
      buf_q.push_back({v, e});
    end
    tick();
    START = 1'b0;
    if (wl) LOAD_VALID = 1'b0;
    n = buf_q.size();
    for (int i = 0; i < n; i++) begin
      x = buf_q[i][3:1];
      if ((x[2] ? x[1] : x[0]) != buf_q[i][0]) begin
        err++;
        mm_q.push_back(cyc + (i + 1) * (h + 1));
      end
    end
    d.cyc = cyc + n * (h + 1);
    d.err = (err > 255) ? 255 : err;
    done_q.push_back(d);
    buf_q.delete();
  endtask

  task automatic wait_done(input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge CLK);
      seen = DONE;
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic load_s1(input logic e2);
    load(3'b001, 1'b1);
    load(3'b010, 1'b0);
    load(3'b110, e2);
    load(3'b101, 1'b0);
  endtask

  logic e8 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    tick();
    tick();
    chk("rst_sba", int'({S, B, A}), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_mismatch", int'(MISMATCH), 0);
    chk("rst_err", int'(ERR_CNT), 0);
    chk("rst_ready", int'(LOAD_READY), 1);
    RST = 1'b0;

    load_s1(1'b1);
    run(0, 1'b0, 3'b000, 1'b0);
    wait_done(20);
    chk("sba_kept_after_done", int'({S, B, A}), 3'b101);

    load_s1(1'b0);
    run(0, 1'b0, 3'b000, 1'b0);
    wait_done(20);

    load(3'b011, 1'b1);
    load(3'b100, 1'b0);
    run(3, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("hold_sba", int'({S, B, A}), (i < 4) ? 3 : 4);
      chk("hold_busy", int'(BUSY), 1);
      tick();
    end
    chk("finish_busy", int'(BUSY), 1);
    chk("finish_done", int'(DONE), 1);
    tick();
    chk("idle_busy", int'(BUSY), 0);

    for (int i = 0; i < 8; i++) load(i[2:0], e8[i]);
    LOAD_VALID = 1'b1;
    LOAD_VEC   = 3'b111;
    LOAD_EXP   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("ready_full", int'(LOAD_READY), 0);
      tick();
    end
    run(0, 1'b0, 3'b000, 1'b0);
    chk("ready_running", int'(LOAD_READY), 0);
    wait_done(40);
    chk("sba_last_of_8", int'({S, B, A}), 7);
    @(negedge CLK);
    chk("ready_after_done", int'(LOAD_READY), 1);
    tick();
    LOAD_VALID = 1'b0;
    buf_q.push_back({3'b111, 1'b1});

    run(0, 1'b1, 3'b010, 1'b0);
    wait_done(20);
    chk("sba_two_vec_run", int'({S, B, A}), 3'b010);

    load_s1(1'b1);
    run(0, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    mm_q.delete();
    done_q.delete();
    buf_q.delete();
    tick();
    RST = 1'b0;
    chk("abort_sba", int'({S, B, A}), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_err", int'(ERR_CNT), 0);
    chk("abort_ready", int'(LOAD_READY), 1);
    chk("abort_done", int'(DONE), 0);
    run(0, 1'b0, 3'b000, 1'b0);
    wait_done(5);

    b_valid = 1'b1;
    repeat (256) tick();
    b_valid = 1'b0;
    chk("big_ready_full", int'(b_ready), 0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge CLK);
        seen = b_done;
      end
      chk("big_done_seen", int'(seen), 1);
    end
    chk("err_saturated", int'(b_err), 255);
    tick();
    chk("err_held", int'(b_err), 255);

    chk("mm_queue_drained", mm_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
